// File: rtl/pkg_dtypes.sv
// Shared datatypes for the exec-unit ALU channels, iqueue opcodes and the
// operand issuer state machine.
package pkg_dtypes;

  localparam int unsigned WORD_WIDTH            = 16;
  localparam int unsigned OPD_ADDR_WIDTH        = 6;
  localparam int unsigned ALU_USE_PIPELINED_ALU = 0;
  localparam int unsigned ISSUER_CNT_W          = 4;

  typedef enum logic [2:0] {
    OPC_ADD,
    OPC_SUB,
    OPC_AND,
    OPC_OR,
    OPC_XOR,
    OPC_NOT,
    OPC_SHL,
    OPC_SHR
  } type_iqueue_opcode;

  typedef struct packed {
    logic [WORD_WIDTH-1:0]     op0_data;
    logic                      op0_valid;
    logic [WORD_WIDTH-1:0]     op1_data;
    logic                      op1_valid;
    logic [OPD_ADDR_WIDTH-1:0] opd_addr;
  } type_alu_channel_rx;

  typedef struct packed {
    logic                      opd_valid;
    logic [OPD_ADDR_WIDTH-1:0] opd_addr;
    logic [WORD_WIDTH-1:0]     opd_data;
  } type_alu_channel_tx;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_RSP0,
    ST_REQ1,
    ST_RSP1,
    ST_EXEC,
    ST_WB
  } type_issuer_state;

endpackage

// File: rtl/issuer_exec_timer.sv
// Execution latency down-counter: load on entry to the exec phase, count
// down while enabled, done once the count reaches zero.
module issuer_exec_timer
  import pkg_dtypes::*;
#(
  parameter int unsigned CNT_W = ISSUER_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_operand_issuer.sv
// Issues one iqueue instruction at a time to the ALU: fetches op0/op1 from the
// operand cache, presents them for the ALU latency and holds the result for writeback.
module alu_operand_issuer
  import pkg_dtypes::*;
#(
  parameter int unsigned DATA_WIDTH        = WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH        = 6,
  parameter int unsigned USE_PIPELINED_ALU = ALU_USE_PIPELINED_ALU,
  parameter int unsigned ALU_PIPE_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  type_iqueue_opcode     instr_i,
  input  logic [ADDR_WIDTH-1:0] instr_op0_addr_i,
  input  logic [ADDR_WIDTH-1:0] instr_op1_addr_i,
  input  logic [ADDR_WIDTH-1:0] instr_opd_addr_i,
  input  logic                  instr_single_op_i,
  output logic                  rd_req_valid_o,
  input  logic                  rd_req_ready_i,
  output logic [ADDR_WIDTH-1:0] rd_req_addr_o,
  input  logic                  rd_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] rd_rsp_data_i,
  output type_alu_channel_rx    alu_rx_o,
  input  type_alu_channel_tx    alu_tx_i,
  output type_iqueue_opcode     curr_instr_o,
  output logic                  curr_instr_valid_o,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o
);

  // Counter preload so EXEC lasts exactly load+1 cycles before capture is allowed.
  localparam logic [ISSUER_CNT_W-1:0] EXEC_LOAD =
    (USE_PIPELINED_ALU != 0) ? ISSUER_CNT_W'(ALU_PIPE_LATENCY) : '0;

  type_issuer_state      state_q, state_d;
  type_iqueue_opcode     opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0] op0_addr_q, op0_addr_d;
  logic [ADDR_WIDTH-1:0] op1_addr_q, op1_addr_d;
  logic [ADDR_WIDTH-1:0] opd_addr_q, opd_addr_d;
  logic                  single_q, single_d;
  logic [DATA_WIDTH-1:0] op0_q, op0_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  timer_load;
  logic                  exec_done;

  issuer_exec_timer #(
    .CNT_W(ISSUER_CNT_W)
  ) u_exec_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (timer_load),
    .load_val_i(EXEC_LOAD),
    .en_i      (state_q == ST_EXEC),
    .done_o    (exec_done)
  );

  always_comb begin
    state_d            = state_q;
    opcode_d           = opcode_q;
    op0_addr_d         = op0_addr_q;
    op1_addr_d         = op1_addr_q;
    opd_addr_d         = opd_addr_q;
    single_d           = single_q;
    op0_d              = op0_q;
    op1_d              = op1_q;
    wb_data_d          = wb_data_q;
    timer_load         = 1'b0;
    instr_ready_o      = 1'b0;
    rd_req_valid_o     = 1'b0;
    rd_req_addr_o      = '0;
    alu_rx_o           = '0;
    alu_rx_o.op0_data  = op0_q;
    alu_rx_o.op1_data  = op1_q;
    alu_rx_o.opd_addr  = opd_addr_q;
    curr_instr_o       = opcode_q;
    curr_instr_valid_o = 1'b0;
    wb_valid_o         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          opcode_d   = instr_i;
          op0_addr_d = instr_op0_addr_i;
          op1_addr_d = instr_op1_addr_i;
          opd_addr_d = instr_opd_addr_i;
          single_d   = instr_single_op_i;
          state_d    = ST_REQ0;
        end
      end
      ST_REQ0: begin
        rd_req_valid_o = 1'b1;
        rd_req_addr_o  = op0_addr_q;
        if (rd_req_ready_i) state_d = ST_RSP0;
      end
      ST_RSP0: begin
        if (rd_rsp_valid_i) begin
          op0_d = rd_rsp_data_i;
          if (single_q) begin
            op1_d      = '0;
            timer_load = 1'b1;
            state_d    = ST_EXEC;
          end else begin
            state_d = ST_REQ1;
          end
        end
      end
      ST_REQ1: begin
        rd_req_valid_o = 1'b1;
        rd_req_addr_o  = op1_addr_q;
        if (rd_req_ready_i) state_d = ST_RSP1;
      end
      ST_RSP1: begin
        if (rd_rsp_valid_i) begin
          op1_d      = rd_rsp_data_i;
          timer_load = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_rx_o.op0_valid = 1'b1;
        alu_rx_o.op1_valid = 1'b1;
        curr_instr_valid_o = 1'b1;
        // Results tagged for another destination are not ours; keep waiting.
        if (exec_done && alu_tx_i.opd_valid && (alu_tx_i.opd_addr == opd_addr_q)) begin
          wb_data_d = alu_tx_i.opd_data;
          state_d   = ST_WB;
        end
      end
      ST_WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      opcode_q   <= OPC_ADD;
      op0_addr_q <= '0;
      op1_addr_q <= '0;
      opd_addr_q <= '0;
      single_q   <= 1'b0;
      op0_q      <= '0;
      op1_q      <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      op0_addr_q <= op0_addr_d;
      op1_addr_q <= op1_addr_d;
      opd_addr_q <= opd_addr_d;
      single_q   <= single_d;
      op0_q      <= op0_d;
      op1_q      <= op1_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_addr_o = opd_addr_q;
  assign wb_data_o = wb_data_q;

endmodule
